// File: rtl/fix_accumulator.sv
// Streaming signed fixed-point sum-of-products stage: adds n_terms products per frame
// in a guard-extended accumulator and emits one saturated result per frame.
module fix_accumulator #(
  parameter int n_int   = 8,
  parameter int n_mant  = 23,
  parameter int n_terms = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_clear,
  input  logic [n_int+n_mant:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [n_int+n_mant:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sat,
  output logic [$clog2(n_terms):0]     count
);
  localparam int N_TOT = n_int + n_mant;
  localparam int W     = N_TOT + 1;
  localparam int G     = $clog2(n_terms);
  localparam int AW    = W + G;
  localparam int CW    = G + 1;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t          state, next_state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   ext;
  logic [AW-1:0]   sum;
  logic [G:0]      hi;
  logic            fits;
  logic [W-1:0]    sat_data;
  logic            accept;
  logic            last;

  assign ext    = {{G{in_data[W-1]}}, in_data};
  assign sum    = acc + ext;
  assign accept = in_valid && in_ready;
  assign last   = (count == CW'(n_terms - 1));

  // Result fits the output format only if sign and guard bits all agree.
  assign hi   = sum[AW-1:N_TOT];
  assign fits = (hi == '0) || (hi == '1);

  always_comb begin
    sat_data = sum[W-1:0];
    if (!fits)
      sat_data = sum[AW-1] ? {1'b1, {N_TOT{1'b0}}} : {1'b0, {N_TOT{1'b1}}};
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    if (in_clear)
      next_state = ACCUM;
    else begin
      case (state)
        ACCUM:   if (accept && last) next_state = HOLD;
        HOLD:    if (out_ready)      next_state = ACCUM;
        default: next_state = ACCUM;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    if (state == HOLD) begin
      in_ready  = out_ready;
      out_valid = 1'b1;
    end
  end

  // Datapath; in_clear discards any beat accepted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (in_clear) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      if (state == ACCUM) begin
        if (last) begin
          out_data <= sat_data;
          out_sat  <= !fits;
          acc      <= '0;
          count    <= '0;
        end else begin
          acc   <= sum;
          count <= count + CW'(1);
        end
      end else begin
        // Zero-bubble restart: the accepting beat opens the next frame.
        acc   <= ext;
        count <= CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fix_accumulator.sv
// Directed bench for fix_accumulator with n_terms=4 (1.0 = 0x00800000).
module tb_fix_accumulator;
  localparam int N_INT = 8, N_MANT = 23, N_TERMS = 4;
  localparam int W = N_INT + N_MANT + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_clear = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_sat;
  logic [2:0]     count;

  int tests_run = 0;
  int fails = 0;

  fix_accumulator #(.n_int(N_INT), .n_mant(N_MANT), .n_terms(N_TERMS)) dut (
    .clk(clk), .rst(rst), .in_clear(in_clear), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sat(out_sat),
    .count(count)
  );

  always #5 clk = ~clk;

  // Present one beat for one clock edge; sampling happens 1 time unit after the edge.
  task automatic drive_beat(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [W-1:0] d0, d1, d2, d3);
    drive_beat(d0); drive_beat(d1); drive_beat(d2); drive_beat(d3);
  endtask

  task automatic release_frame();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
    tests_run++; if (out_sat !== 1'b0) begin fails++; $display("FAIL reset_out_sat got %b want 0", out_sat); end
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    drive_beat(32'h00800000);
    drive_beat(32'h00800000);
    drive_beat(32'h00800000);
    tests_run++; if (count !== 3'd3 || out_valid !== 1'b0) begin fails++; $display("FAIL basic_midframe count=%0d valid=%b want 3/0", count, out_valid); end
    drive_beat(32'h00800000);
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", out_valid); end
    tests_run++; if (out_data !== 32'h02000000) begin fails++; $display("FAIL basic_data got %h want 02000000", out_data); end
    tests_run++; if (out_sat !== 1'b0) begin fails++; $display("FAIL basic_sat got %b want 0", out_sat); end
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL basic_count got %0d want 0", count); end
    @(posedge clk); #1;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_one_cycle got %b want 0", out_valid); end
  endtask

  task automatic test_pos_sat();
    out_ready = 1'b0;
    drive_frame(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    tests_run++; if (out_data !== 32'h7FFFFFFF || out_sat !== 1'b1) begin fails++; $display("FAIL pos_sat data=%h sat=%b want 7fffffff/1", out_data, out_sat); end
    release_frame();
  endtask

  task automatic test_neg_sat();
    out_ready = 1'b0;
    drive_frame(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    tests_run++; if (out_data !== 32'h80000000 || out_sat !== 1'b1) begin fails++; $display("FAIL neg_sat data=%h sat=%b want 80000000/1", out_data, out_sat); end
    release_frame();
  endtask

  task automatic test_guard_bits();
    out_ready = 1'b0;
    drive_frame(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000001, 32'h80000001);
    tests_run++; if (out_data !== 32'h00000000 || out_sat !== 1'b0) begin fails++; $display("FAIL guard data=%h sat=%b want 00000000/0", out_data, out_sat); end
    release_frame();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_frame(32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    in_valid = 1'b1;
    in_data  = 32'h00400000;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
      tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h02000000) begin fails++; $display("FAIL bp_hold cycle %0d valid=%b data=%h want 1/02000000", i, out_valid, out_data); end
      @(posedge clk); #1;
    end
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL bp_stalled_count got %0d want 0", count); end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++; if (count !== 3'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_zero_bubble count=%0d valid=%b want 1/0", count, out_valid); end
    drive_beat(32'h00400000);
    drive_beat(32'h00400000);
    out_ready = 1'b0;
    drive_beat(32'h00400000);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h01000000 || out_sat !== 1'b0) begin fails++; $display("FAIL bp_frame valid=%b data=%h sat=%b want 1/01000000/0", out_valid, out_data, out_sat); end
    release_frame();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    drive_beat(32'h00800000);
    drive_beat(32'h00800000);
    in_clear = 1'b1;
    drive_beat(32'h00800000);
    in_clear = 1'b0;
    tests_run++; if (count !== 3'd0) begin fails++; $display("FAIL clear_count got %0d want 0", count); end
    out_ready = 1'b0;
    drive_frame(32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h01000000) begin fails++; $display("FAIL clear_frame valid=%b data=%h want 1/01000000", out_valid, out_data); end
    in_clear = 1'b1;
    @(posedge clk); #1;
    in_clear = 1'b0;
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL clear_drops_hold got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b0;
    drive_frame(32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    tests_run++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rst_hold_pre got %b want 1", out_valid); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || count !== 3'd0) begin fails++; $display("FAIL rst_hold_async valid=%b count=%0d want 0/0", out_valid, count); end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_frame(32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000);
    tests_run++; if (out_valid !== 1'b1 || out_data !== 32'h02000000 || out_sat !== 1'b0) begin fails++; $display("FAIL rst_next_frame valid=%b data=%h sat=%b want 1/02000000/0", out_valid, out_data, out_sat); end
    release_frame();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_pos_sat();
    test_neg_sat();
    test_guard_bits();
    test_back_to_back();
    test_clear();
    test_reset_in_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/fix_accumulator.md
Name: fix_accumulator

Overview:
- Streaming fixed-point accumulator that sits directly downstream of the fixed-point MULT unit in the control-bounded filter datapath.
- Consumes one product per accepted handshake, in the same signed fixed-point format (n_int integer bits, n_mant fractional bits, plus sign).
- Sums exactly n_terms products per frame using guard bits, then emits one saturated result per frame in the same format.
- Forms the sum-of-products stage of the lookback/lookahead filter.

Parameters:
- n_int, 8, integer bits of the data format (excluding sign)
- n_mant, 23, fractional bits of the data format
- n_terms, 16, products summed per output frame; legal range is n_terms >= 2
- derived: n_tot = n_int+n_mant; n_guard = $clog2(n_terms); accumulator width n_tot+1+n_guard

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- in_clear  input  1  synchronous frame abort
- in_data  input  n_tot+1  signed product from the multiplier
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  n_tot+1  signed saturated frame sum
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- out_sat  output  1  out_data was clipped; qualified by out_valid
- count  output  $clog2(n_terms)+1  terms accepted in the current frame

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ACCUM; acc=0; count=0.
  - out_data=0; out_valid=0; out_sat=0.
  - Reset wins over everything, including mid-frame or while in HOLD; a pending output is lost.
- Accept condition: in_valid && in_ready.
- Sign extension: in_data is sign-extended to the accumulator width before every add. No rounding or shifting is applied; the format is unchanged.
- State ACCUM:
  - in_ready=1; out_valid=0.
  - On accept with count < n_terms-1: acc <= acc+in_data; count <= count+1.
  - On accept with count == n_terms-1:
    - out_data <= sat(acc+in_data); out_sat <= clip flag.
    - acc <= 0; count <= 0.
    - out_valid <= 1; state <= HOLD.
  - Latency: result is visible the cycle after the last term is accepted.
- State HOLD:
  - out_valid=1; out_data and out_sat are held stable until out_ready.
  - in_ready = out_ready (combinational).
  - out_ready=0: nothing changes; inputs are stalled.
  - out_ready=1 with no accept: out_valid <= 0; state <= ACCUM.
  - out_ready=1 with accept (zero-bubble path): out_valid <= 0; acc <= in_data (sign-extended); count <= 1; state <= ACCUM.
  - Sustained throughput is one term per cycle.
- Saturation:
  - MAX = 0 followed by n_tot ones; MIN = 1 followed by n_tot zeros.
  - Full sum > MAX gives MAX; full sum < MIN gives MIN; out_sat=1 in either case.
  - Otherwise out_data = low n_tot+1 bits of the sum and out_sat=0.
  - Intermediate partial sums never saturate; the guard bits cover n_terms × full scale.
- in_clear (synchronous, priority below reset, above everything else):
  - acc <= 0; count <= 0; out_valid <= 0; state <= ACCUM.
  - An in_data beat accepted in the same cycle is discarded.
  - A held output is dropped.
  - in_ready is unaffected by in_clear.
- out_ready while out_valid=0 has no effect.
- in_data is don't-care when in_valid=0.

Test Plan:
All scenarios use n_int=8, n_mant=23, n_terms=4, so 1.0 = 0x00800000.
- Basic sum: four beats of 0x00800000, back-to-back, out_ready=1 → one cycle after the 4th accept, out_valid=1 for 1 cycle, out_data=0x02000000, out_sat=0, count returns to 0.
- Positive saturation: four beats of 0x7FFFFFFF → out_data=0x7FFFFFFF, out_sat=1.
- Negative saturation: four beats of 0x80000000 → out_data=0x80000000, out_sat=1.
- Guard bits: beats 0x7FFFFFFF, 0x7FFFFFFF, 0x80000001, 0x80000001 → out_data=0x00000000, out_sat=0.
- Backpressure: after the frame completes, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and out_data is stable. Then raise out_ready in the same cycle as a beat of 0x00400000 → the beat is accepted, count=1, and the next three beats of 0x00400000 produce 0x01000000.
- Clear and reset: accept 2 beats of 0x00800000, pulse in_clear, then send 4 beats of 0x00400000 → out_data=0x01000000. Separately, assert rst low while in HOLD → out_valid=0 immediately and count=0, and the next full frame sums correctly.
